// File: rtl/wb_addr_arbiter_if.sv
// wb_addr_arbiter_if: requester/downstream bundle of the write-back address arbiter.
// master is the arbiter side; slave is the requester/register-file side.
interface wb_addr_arbiter_if #(parameter int AW = 5);
    logic [3:0]    req;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [AW-1:0] addr3;
    logic          wr_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic          busy;
    modport master (
        input  req, addr0, addr1, addr2, addr3, wr_ready,
        output gnt, sel, wr_valid, wr_addr, busy
    );
    modport slave (
        output req, addr0, addr1, addr2, addr3, wr_ready,
        input  gnt, sel, wr_valid, wr_addr, busy
    );
endinterface

// File: rtl/wb_addr_arbiter.sv
// wb_addr_arbiter: round-robin owner of the shared 4:1 write-back address mux.
// An owner keeps the path for at most MAX_HOLD transfers before rotation.
module wb_addr_arbiter #(
    parameter int AW       = 5,
    parameter int MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst,
    wb_addr_arbiter_if.master bus
);
    localparam logic       IDLE  = 1'b0;
    localparam logic       GRANT = 1'b1;
    localparam logic [2:0] LAST  = 3'(MAX_HOLD - 1);

    logic       state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       xfer, rel, found;
    logic [1:0] start, win;
    logic [3:0] vec;

    function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] s);
        logic [2:0] r;
        logic [1:0] j;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            j = s + 2'(k);
            if (v[j]) r = {1'b1, j};
        end
        return r;
    endfunction

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = state_q == GRANT;
    assign bus.wr_valid = bus.busy & bus.req[sel_q];
    assign bus.wr_addr  = sel_q == 2'd0 ? bus.addr0 :
                          sel_q == 2'd1 ? bus.addr1 :
                          sel_q == 2'd2 ? bus.addr2 : bus.addr3;

    always_comb begin
        xfer         = bus.wr_valid & bus.wr_ready;
        rel          = state_q == GRANT && (!bus.req[sel_q] || (xfer && cnt_q == LAST));
        start        = rel ? sel_q + 2'd1 : ptr_q;
        // On release the outgoing owner cannot win straight back.
        vec          = rel ? bus.req & ~(4'b0001 << sel_q) : bus.req;
        {found, win} = pick(vec, start);
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = rel ? start : ptr_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        if (state_q == IDLE || rel) begin
            state_d = found ? GRANT : IDLE;
            sel_d   = found ? win : sel_q;
            gnt_d   = found ? 4'b0001 << win : 4'b0000;
            cnt_d   = 3'd0;
        end else if (xfer) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 3'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end
endmodule

// File: tb/tb_wb_addr_arbiter.sv
// tb_wb_addr_arbiter: directed vectors with hand-computed expectations.
module tb_wb_addr_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    wb_addr_arbiter_if #(.AW(5)) bus ();

    wb_addr_arbiter #(.AW(5), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.req      = 4'b0000;
        bus.addr0    = 5'b10101;
        bus.addr1    = 5'b11001;
        bus.addr2    = 5'b11000;
        bus.addr3    = 5'b00111;
        bus.wr_ready = 1'b0;
        tick();
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_sel", bus.sel, 2'd0);
        chk("rst_busy", bus.busy, 1'b0);
        bus.req = 4'b1111;
        #1;
        chk("rst_wr_valid", bus.wr_valid, 1'b0);

        // single requester 1: grant latency, then forced release and regrant
        rst          = 1'b0;
        bus.req      = 4'b0010;
        bus.wr_ready = 1'b1;
        #1;
        chk("t1_gnt_before", bus.gnt, 4'b0000);
        tick();
        chk("t1_gnt", bus.gnt, 4'b0010);
        chk("t1_sel", bus.sel, 2'd1);
        chk("t1_wr_valid", bus.wr_valid, 1'b1);
        chk("t1_wr_addr", bus.wr_addr, 5'b11001);
        chk("t1_busy", bus.busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_gnt", bus.gnt, 4'b0010);
        end
        tick();
        chk("t1_idle_gnt", bus.gnt, 4'b0000);
        chk("t1_idle_wr_valid", bus.wr_valid, 1'b0);
        chk("t1_idle_busy", bus.busy, 1'b0);
        chk("t1_idle_sel", bus.sel, 2'd1);
        tick();
        chk("t1_regrant_gnt", bus.gnt, 4'b0010);

        // all requesting: 4 transfers per owner, no bubble
        pulse_rst();
        bus.req = 4'b1111;
        #1;
        chk("t2_after_rst_gnt", bus.gnt, 4'b0000);
        tick();
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 4; c++) begin
                chk("t2_sel", bus.sel, 32'(o % 4));
                chk("t2_gnt", bus.gnt, 32'(4'b0001 << (o % 4)));
                chk("t2_wr_valid", bus.wr_valid, 1'b1);
                tick();
            end
        end
        chk("t2_next_sel", bus.sel, 2'd1);

        // stall on owner 2: nothing moves, count does not advance
        pulse_rst();
        bus.req      = 4'b0100;
        bus.wr_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_sel", bus.sel, 2'd2);
            chk("t3_stall_addr", bus.wr_addr, 5'b11000);
            chk("t3_stall_valid", bus.wr_valid, 1'b1);
            chk("t3_stall_gnt", bus.gnt, 4'b0100);
            tick();
        end
        bus.wr_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_xfer_gnt", bus.gnt, 4'b0100);
        end
        tick();
        chk("t3_release_gnt", bus.gnt, 4'b0000);

        // owner 3 drops mid-grant, requester 0 takes over without a bubble
        pulse_rst();
        bus.req = 4'b1000;
        tick();
        chk("t4_sel", bus.sel, 2'd3);
        chk("t4_addr", bus.wr_addr, 5'b00111);
        tick();
        bus.req = 4'b0001;
        #1;
        chk("t4_drop_valid", bus.wr_valid, 1'b0);
        tick();
        chk("t4_new_gnt", bus.gnt, 4'b0001);
        chk("t4_new_sel", bus.sel, 2'd0);
        chk("t4_new_addr", bus.wr_addr, 5'b10101);
        chk("t4_new_busy", bus.busy, 1'b1);

        // asynchronous reset while owner 2 is busy
        pulse_rst();
        bus.req = 4'b0100;
        tick();
        chk("t6_pre_gnt", bus.gnt, 4'b0100);
        bus.req = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_gnt", bus.gnt, 4'b0000);
        chk("t6_rst_valid", bus.wr_valid, 1'b0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_sel", bus.sel, 2'd0);
        rst = 1'b0;
        tick();
        chk("t6_first_gnt", bus.gnt, 4'b0001);
        chk("t6_first_sel", bus.sel, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
